// File: rtl/display_scan_bcd.sv
// Binary-to-BCD converter (sequential double-dabble) feeding a 4-digit
// time-multiplexed display scan with leading-zero blanking.
module display_scan_bcd #(
   parameter int unsigned REFRESH_DIV = 50000,
   parameter int unsigned BIN_W       = 14
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [BIN_W-1:0] value,
   input  logic             load,
   output logic             busy,
   output logic             ovf,
   output logic [3:0]       digit,
   output logic [3:0]       an
);

   localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int unsigned SC_W  = $clog2(BIN_W);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
   localparam logic [SC_W-1:0]  SC_LAST  = SC_W'(BIN_W - 1);
   localparam logic [BIN_W-1:0] MAX_DEC  = BIN_W'(9999);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SHIFT = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [BIN_W-1:0] bin_q, bin_d;
   logic [15:0]      bcd_q, bcd_d;
   logic [SC_W-1:0]  sc_q, sc_d;
   logic             pend_q, pend_d;
   logic [15:0]      disp_q, disp_d;
   logic             ovf_q, ovf_d;
   logic             busy_q, busy_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       idx_q, idx_d;
   logic [3:0]       digit_q, digit_d;
   logic [3:0]       an_q, an_d;
   logic [15:0]      adj;
   logic             blank;

   // Conversion FSM: saturate on load, shift-add-3 for BIN_W cycles, commit atomically.
   always_comb begin
      state_d = state_q;
      bin_d   = bin_q;
      bcd_d   = bcd_q;
      sc_d    = sc_q;
      pend_d  = pend_q;
      disp_d  = disp_q;
      ovf_d   = ovf_q;
      adj     = bcd_q;
      case (state_q)
         S_IDLE: begin
            if (load) begin
               pend_d  = (value > MAX_DEC);
               bin_d   = pend_d ? MAX_DEC : value;
               bcd_d   = '0;
               sc_d    = '0;
               state_d = S_SHIFT;
            end
         end
         S_SHIFT: begin
            for (int i = 0; i < 4; i++) begin
               if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
            end
            bcd_d = {adj[14:0], bin_q[BIN_W-1]};
            bin_d = {bin_q[BIN_W-2:0], 1'b0};
            sc_d  = sc_q + SC_W'(1);
            if (sc_q == SC_LAST) state_d = S_DONE;
         end
         S_DONE: begin
            disp_d  = bcd_q;
            ovf_d   = pend_q;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      busy_d = (state_d != S_IDLE);
   end

   // Free-running scan; outputs follow the next index and next display contents.
   always_comb begin
      cnt_d = cnt_q + CNT_W'(1);
      idx_d = idx_q;
      if (cnt_q == CNT_LAST) begin
         cnt_d = '0;
         idx_d = idx_q + 2'd1;
      end
      digit_d = disp_d[{idx_d, 2'b00} +: 4];
      case (idx_d)
         2'd1:    blank = (disp_d[15:4]  == 12'h000);
         2'd2:    blank = (disp_d[15:8]  == 8'h00);
         2'd3:    blank = (disp_d[15:12] == 4'h0);
         default: blank = 1'b0;
      endcase
      an_d = blank ? 4'hF : ~(4'b0001 << idx_d);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         bin_q   <= '0;
         bcd_q   <= '0;
         sc_q    <= '0;
         pend_q  <= 1'b0;
         disp_q  <= '0;
         ovf_q   <= 1'b0;
         busy_q  <= 1'b0;
         cnt_q   <= '0;
         idx_q   <= '0;
         digit_q <= 4'h0;
         an_q    <= 4'b1110;
      end else begin
         state_q <= state_d;
         bin_q   <= bin_d;
         bcd_q   <= bcd_d;
         sc_q    <= sc_d;
         pend_q  <= pend_d;
         disp_q  <= disp_d;
         ovf_q   <= ovf_d;
         busy_q  <= busy_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         digit_q <= digit_d;
         an_q    <= an_d;
      end
   end

   assign busy  = busy_q;
   assign ovf   = ovf_q;
   assign digit = digit_q;
   assign an    = an_q;

endmodule

// File: tb/tb_display_scan_bcd.sv
// Randomized self-checking bench for display_scan_bcd against a decimal-arithmetic display model.
module tb_display_scan_bcd;

   localparam int unsigned DIV = 4;
   localparam int unsigned W   = 14;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         load = 1'b0;
   logic [W-1:0] value = '0;
   logic         busy, ovf;
   logic [3:0]   digit, an;

   int   n_cmp = 0;
   int   n_bad = 0;
   int   edges = 0;
   int   cur_val = 0;
   logic cur_ovf = 1'b0;

   display_scan_bcd #(.REFRESH_DIV(DIV), .BIN_W(W)) dut (
      .clk(clk), .rst(rst), .value(value), .load(load),
      .busy(busy), .ovf(ovf), .digit(digit), .an(an)
   );

   always #5 clk = ~clk;

   // Clock edges since the last reset edge; the scan slot is edges/DIV mod 4.
   always @(posedge clk) begin
      if (rst) edges <= 0;
      else     edges <= edges + 1;
   end

   function automatic int sat(input int v);
      return (v > 9999) ? 9999 : v;
   endfunction

   function automatic int pow10(input int n);
      int p = 1;
      for (int j = 0; j < n; j++) p = p * 10;
      return p;
   endfunction

   function automatic logic [3:0] exp_digit(input int v, input int idx);
      return 4'((sat(v) / pow10(idx)) % 10);
   endfunction

   function automatic logic [3:0] exp_an(input int v, input int idx);
      logic [3:0] one_hot;
      if (idx > 0 && sat(v) < pow10(idx)) return 4'hF;
      one_hot = 4'b0001 << idx;
      return ~one_hot;
   endfunction

   function automatic int cur_idx();
      return (edges / DIV) % 4;
   endfunction

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      cur_val = 0;
      cur_ovf = 1'b0;
      n_cmp += 4;
      if (busy !== 1'b0)   begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
      if (ovf !== 1'b0)    begin n_bad++; $display("FAIL reset_ovf: got %b want 0", ovf); end
      if (an !== 4'b1110)  begin n_bad++; $display("FAIL reset_an: got %b want 1110", an); end
      if (digit !== 4'h0)  begin n_bad++; $display("FAIL reset_digit: got %h want 0", digit); end
      for (int i = 0; i < 4 * 4 * DIV; i++) begin
         @(negedge clk);
         n_cmp += 2;
         if (an !== exp_an(0, cur_idx()))
            begin n_bad++; $display("FAIL idle_scan_an: got %b want %b", an, exp_an(0, cur_idx())); end
         if (digit !== 4'h0)
            begin n_bad++; $display("FAIL idle_scan_digit: got %h want 0", digit); end
      end
   endtask

   // Load one value, check busy window and frozen display, then the new scan.
   task automatic test_convert(input int v, input string name);
      int   old_val;
      logic old_ovf;
      int   waited;
      waited = 0;
      while (busy !== 1'b0 && waited < 100) begin @(negedge clk); waited++; end
      n_cmp++;
      if (busy !== 1'b0) begin n_bad++; $display("FAIL %s_idle_wait: busy=%b want 0", name, busy); end
      old_val = cur_val;
      old_ovf = cur_ovf;
      load  = 1'b1;
      value = W'(v);
      for (int i = 0; i < int'(W) + 1; i++) begin
         @(negedge clk);
         load = 1'b0;
         n_cmp += 4;
         if (busy !== 1'b1)
            begin n_bad++; $display("FAIL %s_busy[%0d]: got %b want 1", name, i, busy); end
         if (ovf !== old_ovf)
            begin n_bad++; $display("FAIL %s_ovf_hold[%0d]: got %b want %b", name, i, ovf, old_ovf); end
         if (an !== exp_an(old_val, cur_idx()))
            begin n_bad++; $display("FAIL %s_an_hold[%0d]: got %b want %b", name, i, an, exp_an(old_val, cur_idx())); end
         if (digit !== exp_digit(old_val, cur_idx()))
            begin n_bad++; $display("FAIL %s_digit_hold[%0d]: got %h want %h", name, i, digit, exp_digit(old_val, cur_idx())); end
      end
      cur_val = v;
      cur_ovf = (v > 9999);
      for (int i = 0; i < 4 * 2 * DIV; i++) begin
         if (i > 0) @(negedge clk);
         else       @(negedge clk);
         n_cmp += 4;
         if (busy !== 1'b0)
            begin n_bad++; $display("FAIL %s_busy_low[%0d]: got %b want 0", name, i, busy); end
         if (ovf !== cur_ovf)
            begin n_bad++; $display("FAIL %s_ovf[%0d]: got %b want %b", name, i, ovf, cur_ovf); end
         if (an !== exp_an(cur_val, cur_idx()))
            begin n_bad++; $display("FAIL %s_an[%0d]: got %b want %b", name, i, an, exp_an(cur_val, cur_idx())); end
         if (digit !== exp_digit(cur_val, cur_idx()))
            begin n_bad++; $display("FAIL %s_digit[%0d]: got %h want %h", name, i, digit, exp_digit(cur_val, cur_idx())); end
      end
   endtask

   task automatic test_directed();
      test_convert(1234, "v1234");
      test_convert(7, "v7");
      test_convert(1005, "v1005");
      test_convert(0, "v0");
   endtask

   task automatic test_overflow();
      test_convert(12000, "v12000");
      test_convert(42, "v42_after_ovf");
      test_convert(16383, "vmax");
      test_convert(9999, "v9999");
      test_convert(10000, "v10000");
   endtask

   task automatic test_random();
      for (int n = 0; n < 12; n++) begin
         if (n % 3 == 0) test_convert(int'($urandom_range(0, 16383)), "rand_any");
         else            test_convert(int'($urandom_range(0, 9999)), "rand_dec");
      end
   endtask

   task automatic test_load_while_busy();
      int old_val;
      old_val = cur_val;
      @(negedge clk);
      load  = 1'b1;
      value = W'(1234);
      for (int i = 0; i < int'(W) + 1; i++) begin
         @(negedge clk);
         load = 1'b0;
         if (i == 2) begin load = 1'b1; value = W'(5678); end
         n_cmp += 2;
         if (busy !== 1'b1)
            begin n_bad++; $display("FAIL lwb_busy[%0d]: got %b want 1", i, busy); end
         if (an !== exp_an(old_val, cur_idx()) || digit !== exp_digit(old_val, cur_idx()))
            begin n_bad++; $display("FAIL lwb_hold[%0d]: got an=%b d=%h want an=%b d=%h", i, an, digit,
                                    exp_an(old_val, cur_idx()), exp_digit(old_val, cur_idx())); end
      end
      load = 1'b0;
      cur_val = 1234;
      cur_ovf = 1'b0;
      for (int i = 0; i < 4 * 2 * DIV; i++) begin
         @(negedge clk);
         n_cmp += 3;
         if (busy !== 1'b0)
            begin n_bad++; $display("FAIL lwb_no_queue[%0d]: busy=%b want 0", i, busy); end
         if (an !== exp_an(1234, cur_idx()))
            begin n_bad++; $display("FAIL lwb_an[%0d]: got %b want %b", i, an, exp_an(1234, cur_idx())); end
         if (digit !== exp_digit(1234, cur_idx()))
            begin n_bad++; $display("FAIL lwb_digit[%0d]: got %h want %h", i, digit, exp_digit(1234, cur_idx())); end
      end
   endtask

   task automatic test_reset_mid();
      int old_val;
      old_val = cur_val;
      @(negedge clk);
      load  = 1'b1;
      value = W'(9999);
      // Negedges after edges k..k+7; rst is raised so that edge k+8 (8th shift) samples it.
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         load = 1'b0;
         n_cmp++;
         if (busy !== 1'b1) begin n_bad++; $display("FAIL rmid_busy[%0d]: got %b want 1", i, busy); end
         if (i == 7) rst = 1'b1;
      end
      @(negedge clk);
      rst = 1'b0;
      cur_val = 0;
      cur_ovf = 1'b0;
      n_cmp += 3;
      if (busy !== 1'b0)  begin n_bad++; $display("FAIL rmid_busy_clr: got %b want 0", busy); end
      if (an !== 4'b1110) begin n_bad++; $display("FAIL rmid_an: got %b want 1110", an); end
      if (digit !== 4'h0) begin n_bad++; $display("FAIL rmid_digit: got %h want 0", digit); end
      for (int i = 0; i < 4 * 3 * DIV; i++) begin
         @(negedge clk);
         n_cmp += 4;
         if (busy !== 1'b0) begin n_bad++; $display("FAIL rmid_aborted[%0d]: busy=%b want 0", i, busy); end
         if (ovf !== 1'b0)  begin n_bad++; $display("FAIL rmid_ovf[%0d]: got %b want 0", i, ovf); end
         if (an !== exp_an(0, cur_idx()))
            begin n_bad++; $display("FAIL rmid_an_scan[%0d]: got %b want %b", i, an, exp_an(0, cur_idx())); end
         if (digit !== 4'h0)
            begin n_bad++; $display("FAIL rmid_digit_scan[%0d]: got %h want 0", i, digit); end
      end
      if (old_val < 0) $display("note: unexpected negative prior value");
   endtask

   initial begin
      test_reset();
      test_directed();
      test_overflow();
      test_random();
      test_convert(42, "pre_lwb");
      test_load_while_busy();
      test_convert(321, "pre_rmid");
      test_reset_mid();
      test_convert(908, "after_rmid");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/display_scan_bcd.md
Name: display_scan_bcd

Overview:
- Upstream stage of the active-low seven-segment decoder.
- Accepts a binary value on a load strobe and converts it to four BCD digits with a sequential shift-add-3 (double-dabble) engine.
- Time-multiplexes the four digits onto one shared 4-bit nibble bus plus active-low anode enables.
- The nibble bus feeds the decoder inputs directly: digit[3]→in0 (MSB) … digit[0]→in3 (LSB).

Parameters:
- REFRESH_DIV, 50000: clock cycles each digit is held before the scan advances. Legal range ≥1.
- BIN_W, 14: width of the binary input. Legal range 14..16.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- value  input  BIN_W  unsigned binary value to display.
- load  input  1  one-cycle strobe; value sampled when load=1 and busy=0.
- busy  output  1  conversion in progress.
- ovf  output  1  last accepted value exceeded 9999.
- digit  output  4  BCD nibble for the decoder; digit[3] is MSB.
- an  output  4  anode enables, active-low; an[0] is the ones digit (rightmost).

Behaviour:
- Reset values: busy=0, ovf=0, an=4'b1110, digit=4'h0. Display regs disp0..disp3=0, scan index=0, refresh counter=0, FSM=IDLE.
- Reset asserted mid-conversion aborts the conversion and clears the display regs to 0.
- FSM states:
  - IDLE: if load=1, sample value; go to SHIFT. Saturate first: if value>9999, convert 9999 and set pending ovf=1; otherwise pending ovf=0.
  - SHIFT: exactly BIN_W cycles. Each cycle, add 3 to every BCD nibble ≥5, then shift {bcd,bin} left by 1. Shift count reaches BIN_W-1 → go to DONE.
  - DONE: one cycle. Copy the BCD result to disp0..disp3 and the pending flag to ovf, all atomically. Go to IDLE.
- busy=1 in SHIFT and DONE. With load sampled at edge k, busy is high for BIN_W+1 cycles after edge k. New digits and ovf are visible after edge k+BIN_W+1 (k+15 at default).
- load while busy: ignored, no queuing. The display holds the previous value throughout a conversion; no partial digits ever appear.
- Simultaneous rst and load: reset wins.
- Scan:
  - Refresh counter counts 0..REFRESH_DIV-1 and wraps.
  - On wrap, the scan index advances 0→1→2→3→0.
  - REFRESH_DIV=1 advances the index every cycle.
  - Scanning runs continuously, independent of the conversion FSM; a display-reg update does not reset the scan.
- Registered outputs: digit = disp[index]; an = all ones except bit index = 0. Both update on the same edge as the index.
- Leading-zero blanking: a digit position above the most-significant nonzero digit drives its an bit high while selected. The ones position is never blanked; value 0 shows a single "0". digit still carries the nibble (0) when blanked.
- ovf does not blank the display; saturated 9999 is shown.
- Counter widths: refresh counter sized by $clog2(REFRESH_DIV); no overflow beyond the wrap point.

Test Plan (REFRESH_DIV=4, BIN_W=14):
- Hold rst 3 cycles, release → an=1110, digit=0, busy=0, ovf=0. Scan then cycles an 1110→1101→1011→0111 with the upper three blanked (an stays 1111 on those slots), every 4 cycles.
- load value=1234 at edge k → busy=1 for 15 cycles; digits update after edge k+15. Scan shows (an,digit) = (1110,4), (1101,3), (1011,2), (0111,1), each held 4 cycles, then repeats.
- load value=7 → ones slot an=1110, digit=7; slots 1..3 an=1111. load value=1005 → no blanking; digits 5,0,0,1.
- load value=12000 → digits 9,9,9,9 and ovf=1. A subsequent load of 42 → ovf=0; display 2,4 with the upper two slots blanked.
- load 1234, then pulse load with 5678 three cycles later (busy=1) → second load ignored; final display 1234, busy falls after 15 cycles.
- load 9999, then assert rst on the 8th SHIFT cycle → next cycle busy=0, disp all 0, an=1110. No 9999 ever appears.
